// File: rtl/jpeg_rle_block_decoder_if.sv
//------------------------------------------------------------------------------
// Module      : jpeg_rle_block_decoder_if
// Description : Symbol-in / coefficient-out handshake bundle for the RLE decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface jpeg_rle_block_decoder_if #(
    parameter int AMP_W  = 11,
    parameter int COEF_W = 12
);
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               in_run;
    logic [3:0]               in_size;
    logic [AMP_W-1:0]         in_bits;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [COEF_W-1:0] out_coef;
    logic [5:0]               out_index;
    logic                     out_last;

    // Symbol source and coefficient sink
    modport master (
        output in_valid, in_run, in_size, in_bits, out_ready,
        input  in_ready, out_valid, out_coef, out_index, out_last
    );

    // Decoder
    modport slave (
        input  in_valid, in_run, in_size, in_bits, out_ready,
        output in_ready, out_valid, out_coef, out_index, out_last
    );
endinterface

`default_nettype wire

// File: rtl/jpeg_rle_block_decoder.sv
//------------------------------------------------------------------------------
// Module      : jpeg_rle_block_decoder
// Description : Rebuilds 64 zigzag-ordered coefficients per 8x8 block from
//               (run, size, bits) symbols: DC prediction, zero runs, ZRL, EOB.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jpeg_rle_block_decoder #(
    parameter int AMP_W  = 11,
    parameter int COEF_W = 12
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               restart_i,
    output logic                    err_o,
    jpeg_rle_block_decoder_if.slave bus
);

    localparam logic [5:0] LAST_IDX = 6'd63;

    typedef enum logic [2:0] {
        S_DC   = 3'd0,
        S_AC   = 3'd1,
        S_RUN  = 3'd2,
        S_VAL  = 3'd3,
        S_FILL = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [5:0]               idx_q, idx_d;
    logic [3:0]               run_cnt_q, run_cnt_d;
    logic signed [COEF_W-1:0] amp_q, amp_d;
    logic signed [COEF_W-1:0] dc_pred_q, dc_pred_d;
    logic                     err_q, err_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [COEF_W-1:0] out_coef_q, out_coef_d;
    logic [5:0]               out_index_q, out_index_d;
    logic                     out_last_q, out_last_d;

    logic                     w_adv;
    logic                     w_accept;
    logic [3:0]               w_size;
    logic [COEF_W-1:0]        w_mask;
    logic [COEF_W-1:0]        w_mag;
    logic [COEF_W-1:0]        w_top;
    logic signed [COEF_W-1:0] w_amp;
    logic signed [COEF_W-1:0] w_pred;
    logic signed [COEF_W-1:0] w_dc_coef;
    logic                     w_overrun;
    logic                     w_emit;
    logic signed [COEF_W-1:0] w_val;

    assign w_adv        = !out_valid_q || bus.out_ready;
    assign bus.in_ready = w_adv && ((state_q == S_DC) || (state_q == S_AC));
    assign w_accept     = bus.in_valid && bus.in_ready;

    // w_top isolates bit s-1: the sign-select bit of the amplitude category
    always_comb begin
        w_size = (bus.in_size > 4'(AMP_W)) ? 4'(AMP_W) : bus.in_size;
        w_mask = (COEF_W'(1) << w_size) - COEF_W'(1);
        w_mag  = COEF_W'(bus.in_bits) & w_mask;
        w_top  = w_mask & ~(w_mask >> 1);
        w_amp  = (|(w_mag & w_top)) ? w_mag : (w_mag - w_mask);
    end

    assign w_pred    = restart_i ? '0 : dc_pred_q;
    assign w_dc_coef = w_pred + w_amp;
    assign w_overrun = ({1'b0, idx_q} + {3'b000, bus.in_run}) > 7'd63;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_cnt_d = run_cnt_q;
        amp_d     = amp_q;
        dc_pred_d = w_pred;
        err_d     = err_q;
        w_emit    = 1'b0;
        w_val     = '0;

        if (w_adv) begin
            case (state_q)
                S_DC: begin
                    if (w_accept) begin
                        w_emit    = 1'b1;
                        w_val     = w_dc_coef;
                        dc_pred_d = w_dc_coef;
                        state_d   = S_AC;
                    end
                end
                S_AC: begin
                    if (w_accept) begin
                        w_emit = 1'b1;
                        if ((bus.in_run == 4'd0) && (bus.in_size == 4'd0)) begin
                            state_d = S_FILL;
                        end else if (bus.in_run == 4'd0) begin
                            w_val = w_amp;
                        end else begin
                            // First zero of the run goes out now so runs have no bubble;
                            // ZRL is simply run 15 with a zero-valued amplitude.
                            amp_d     = w_amp;
                            run_cnt_d = bus.in_run - 4'd1;
                            state_d   = (bus.in_run == 4'd1) ? S_VAL : S_RUN;
                            if (w_overrun) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    w_emit    = 1'b1;
                    run_cnt_d = run_cnt_q - 4'd1;
                    if (run_cnt_q == 4'd1) begin
                        state_d = S_VAL;
                    end
                end
                S_VAL: begin
                    w_emit  = 1'b1;
                    w_val   = amp_q;
                    state_d = S_AC;
                end
                S_FILL: begin
                    w_emit = 1'b1;
                end
                default: begin
                    state_d = S_DC;
                    idx_d   = '0;
                end
            endcase
        end

        // Any emission at the last index closes the block, dropping pending run/value
        if (w_emit) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_DC;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 6'd1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_coef_d  = out_coef_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        if (w_adv) begin
            out_valid_d = w_emit;
            out_coef_d  = w_val;
            out_index_d = idx_q;
            out_last_d  = w_emit && (idx_q == LAST_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DC;
            idx_q       <= '0;
            run_cnt_q   <= '0;
            amp_q       <= '0;
            dc_pred_q   <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_coef_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_cnt_q   <= run_cnt_d;
            amp_q       <= amp_d;
            dc_pred_q   <= dc_pred_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_coef_q  <= out_coef_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_coef  = out_coef_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_jpeg_rle_block_decoder.sv
//------------------------------------------------------------------------------
// Module      : tb_jpeg_rle_block_decoder
// Description : Directed self-checking bench for jpeg_rle_block_decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jpeg_rle_block_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic restart;
    logic err;

    jpeg_rle_block_decoder_if bus_if ();

    jpeg_rle_block_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (restart),
        .err_o     (err),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int q_coef[$];
    int q_idx[$];
    int q_last[$];
    int exp_c[64];

    logic        bp_en = 1'b0;
    logic [15:0] lfsr  = 16'hACE1;
    logic        stall_prev = 1'b0;
    int          prev_coef, prev_idx, prev_last;

    // AC symbol table for the 20-symbol block (DC + 18 AC + EOB)
    int t_r[18] = '{0, 1, 0,     2, 0, 0,      0, 0,      1, 0,  0,  3, 0,  0, 1, 0,      0, 0};
    int t_s[18] = '{1, 2, 2,     3, 4, 11,     11, 12,    1, 5,  5,  1, 6,  1, 3, 2,      3, 1};
    int t_b[18] = '{1, 2, 'h7FC, 7, 0, 'h400,  0, 'h7FF,  0, 16, 15, 1, 63, 0, 3, 'h7FF,  4, 1};

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 64; i++) exp_c[i] = 0;
    endtask

    task automatic send(input int r, input int s, input int b, input bit rs);
        int n  = 0;
        bit ok = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_run   = 4'(r);
        bus_if.in_size  = 4'(s);
        bus_if.in_bits  = 11'(b);
        restart         = rs;
        while (!ok && n < 2000) begin
            @(negedge clk);
            ok = bus_if.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus_if.in_valid = 1'b0;
        restart         = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic check_block(input string tag);
        int n = 0;
        while (q_coef.size() < 64 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (q_coef.size() < 64) begin
            chk({tag, "_timeout"}, q_coef.size(), 64);
        end else begin
            for (int i = 0; i < 64; i++) begin
                chk($sformatf("%s_idx[%0d]", tag, i), q_idx.pop_front(), i);
                chk($sformatf("%s_last[%0d]", tag, i), q_last.pop_front(), (i == 63) ? 1 : 0);
                chk($sformatf("%s_coef[%0d]", tag, i), q_coef.pop_front(), exp_c[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            bus_if.out_ready = bp_en ? (lfsr[0] | lfsr[5]) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", int'(bus_if.out_valid), 1);
                chk("stall_coef", int'(bus_if.out_coef), prev_coef);
                chk("stall_idx", int'(bus_if.out_index), prev_idx);
                chk("stall_last", int'(bus_if.out_last), prev_last);
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                q_coef.push_back(int'(bus_if.out_coef));
                q_idx.push_back(int'(bus_if.out_index));
                q_last.push_back(int'(bus_if.out_last));
            end
            if (bus_if.out_valid && !bus_if.out_ready) begin
                chk("stall_in_ready", int'(bus_if.in_ready), 0);
            end
            stall_prev = bus_if.out_valid && !bus_if.out_ready;
            prev_coef  = int'(bus_if.out_coef);
            prev_idx   = int'(bus_if.out_index);
            prev_last  = int'(bus_if.out_last);
        end
    end

    initial begin
        rst_n           = 1'b0;
        restart         = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_run   = '0;
        bus_if.in_size  = '0;
        bus_if.in_bits  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(bus_if.out_valid), 0);
        chk("rst_out_coef", int'(bus_if.out_coef), 0);
        chk("rst_out_index", int'(bus_if.out_index), 0);
        chk("rst_out_last", int'(bus_if.out_last), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_in_ready", int'(bus_if.in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DC +5 from zero predictor, then EOB
        clr_exp(); exp_c[0] = 5;
        send(0, 3, 'b101, 1'b0); send(0, 0, 0, 1'b0);
        check_block("basic");

        // DC diff 1-3 = -2 on predictor 5
        clr_exp(); exp_c[0] = 3;
        send(0, 2, 'b01, 1'b0); send(0, 0, 0, 1'b0);
        check_block("dc_pred");

        // restart with the DC: predictor 0; run of 2 then +1, then -5
        clr_exp(); exp_c[3] = 1; exp_c[4] = -5;
        send(0, 0, 0, 1'b1); send(2, 1, 1, 1'b0); send(0, 3, 'b010, 1'b0); send(0, 0, 0, 1'b0);
        check_block("run_neg");

        // three ZRLs and a run of 14 ending with -1 at index 63, no EOB
        clr_exp(); exp_c[0] = 1; exp_c[63] = -1;
        send(0, 1, 1, 1'b0);
        send(15, 0, 0, 1'b0); send(15, 0, 0, 1'b0); send(15, 0, 0, 1'b0);
        send(14, 1, 0, 1'b0);
        check_block("zrl");

        // overflow: run of 3 at index 63
        clr_exp(); exp_c[0] = 1;
        for (int i = 1; i <= 62; i++) exp_c[i] = 1;
        send(0, 0, 0, 1'b0);
        for (int i = 0; i < 62; i++) send(0, 1, 1, 1'b0);
        chk("err_before_ovf", int'(err), 0);
        send(3, 1, 1, 1'b0);
        check_block("ovf");
        chk("err_after_ovf", int'(err), 1);

        // symbol after overflow is a DC: predictor 1 + 3
        clr_exp(); exp_c[0] = 4;
        send(0, 2, 'b11, 1'b0); send(0, 0, 0, 1'b0);
        check_block("after_ovf");
        chk("err_sticky", int'(err), 1);

        // table block, first free-running then under backpressure
        for (int pass = 0; pass < 2; pass++) begin
            bp_en = (pass == 1);
            clr_exp();
            exp_c[0]  = (pass == 0) ? 3 : 2;
            exp_c[1]  = 1;     exp_c[3]  = 2;     exp_c[4]  = -3;   exp_c[7]  = 7;
            exp_c[8]  = -15;   exp_c[9]  = 1024;  exp_c[10] = -2047; exp_c[11] = 2047;
            exp_c[13] = -1;    exp_c[14] = 16;    exp_c[15] = -16;  exp_c[19] = 1;
            exp_c[20] = 63;    exp_c[21] = -1;    exp_c[23] = -4;   exp_c[24] = 3;
            exp_c[25] = 4;     exp_c[26] = 1;
            send(0, 1, 0, 1'b0);
            for (int k = 0; k < 18; k++) send(t_r[k], t_s[k], t_b[k], 1'b0);
            send(0, 0, 0, 1'b0);
            check_block((pass == 0) ? "tbl" : "bp");
        end
        bp_en = 1'b0;

        // restart pulse between blocks
        clr_exp(); exp_c[0] = 7;
        send(0, 3, 7, 1'b1); send(0, 0, 0, 1'b0);
        check_block("dc7");
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        clr_exp(); exp_c[0] = 1;
        send(0, 1, 1, 1'b0); send(0, 0, 0, 1'b0);
        check_block("restart");

        // asynchronous reset in the middle of a zero run
        send(0, 0, 0, 1'b0);
        send(10, 1, 1, 1'b0);
        @(posedge clk);
        #3;
        chk("err_before_rst", int'(err), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus_if.out_valid), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_out_index", int'(bus_if.out_index), 0);
        chk("midrst_in_ready", int'(bus_if.in_ready), 1);
        q_coef.delete(); q_idx.delete(); q_last.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clr_exp(); exp_c[0] = 2;
        send(0, 2, 'b10, 1'b0); send(0, 0, 0, 1'b0);
        check_block("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
